// File: rtl/connect_mc_pkg.sv
// Shared definitions for the connect_mc request concentrator:
// FSM state encoding and a helper for locating a slice in a flattened bus.
package connect_mc_pkg;

   typedef logic [1:0] state_t;

   // One transaction walks IDLE -> REQ -> RESP -> RET -> IDLE.
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_REQ  = 2'd1;
   localparam state_t ST_RESP = 2'd2;
   localparam state_t ST_RET  = 2'd3;

   // Lowest bit position of slice 'idx' in a bus built from 'width'-bit slices.
   function automatic int slice_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/connect_mc_prio_enc.sv
// Fixed-priority encoder: the highest set request bit wins.
// Produces a one-hot grant, the winner's binary index and an any-request flag.
module connect_mc_prio_enc #(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   // Scan upward so a higher set bit overrides any lower winner.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req_i[i]) begin
            gnt_o    = '0;
            gnt_o[i] = 1'b1;
            idx_o    = IDX_W'(i);
            any_o    = 1'b1;
         end else begin
            // lower-index winner (if any) stays in place
         end
      end
   end

endmodule

// File: rtl/connect_mc.sv
// connect_mc: N-to-1 memory-request concentrator. One request at a time is
// granted (highest slave index first), forwarded to the master, and the
// master's response is returned to the slave that issued it.
module connect_mc
   import connect_mc_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int CONNECT_NUM = 3
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic [CONNECT_NUM-1:0]            SLAVE_RECEIVE_ADDR_VALID,
   input  logic [ADDR_WIDTH*CONNECT_NUM-1:0] SLAVE_RECEIVE_ADDR,
   input  logic [CONNECT_NUM-1:0]            SLAVE_RECEIVE_DATA_VALID,
   input  logic [DATA_WIDTH*CONNECT_NUM-1:0] SLAVE_RECEIVE_DATA,
   output logic [CONNECT_NUM-1:0]            SLAVE_RECEIVE_READY,
   output logic [CONNECT_NUM-1:0]            SLAVE_SEND_VALID,
   output logic [DATA_WIDTH*CONNECT_NUM-1:0] SLAVE_SEND_DATA,
   input  logic [CONNECT_NUM-1:0]            SLAVE_SEND_READY,
   output logic                              MASTER_SEND_ADDR_VALID,
   output logic [ADDR_WIDTH-1:0]             MASTER_SEND_ADDR,
   output logic                              MASTER_SEND_DATA_VALID,
   output logic [DATA_WIDTH-1:0]             MASTER_SEND_DATA,
   input  logic                              MASTER_SEND_READY,
   input  logic                              MASTER_RECEIVE_VALID,
   input  logic [DATA_WIDTH-1:0]             MASTER_RECEIVE_DATA,
   output logic                              MASTER_RECEIVE_READY
);

   localparam int IDX_W = (CONNECT_NUM > 1) ? $clog2(CONNECT_NUM) : 1;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    dv_q, dv_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   resp_q, resp_d;

   logic [CONNECT_NUM-1:0]  gnt_s;
   logic [IDX_W-1:0]        gnt_idx_s;
   logic                    any_s;
   logic [ADDR_WIDTH-1:0]   sel_addr_s;
   logic [DATA_WIDTH-1:0]   sel_data_s;
   logic                    sel_dv_s;
   logic [CONNECT_NUM-1:0]  ret_vec_s;
   logic                    ret_ack_s;

   connect_mc_prio_enc #(
      .N     (CONNECT_NUM),
      .IDX_W (IDX_W)
   ) u_prio_enc (
      .req_i (SLAVE_RECEIVE_ADDR_VALID),
      .gnt_o (gnt_s),
      .idx_o (gnt_idx_s),
      .any_o (any_s)
   );

   // Select the granted slave's address, data and data-valid flag.
   always_comb begin
      sel_addr_s = '0;
      sel_data_s = '0;
      sel_dv_s   = 1'b0;
      for (int i = 0; i < CONNECT_NUM; i++) begin
         if (gnt_s[i]) begin
            sel_addr_s = SLAVE_RECEIVE_ADDR[slice_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
            sel_data_s = SLAVE_RECEIVE_DATA[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
            sel_dv_s   = SLAVE_RECEIVE_DATA_VALID[i];
         end else begin
            // not the granted slice
         end
      end
   end

   // Decode the captured index into the one-hot response valid; the response
   // is released only by the ready of that same slave.
   always_comb begin
      ret_vec_s = '0;
      for (int i = 0; i < CONNECT_NUM; i++) begin
         ret_vec_s[i] = (state_q == ST_RET) && (idx_q == IDX_W'(i));
      end
      ret_ack_s = |(ret_vec_s & SLAVE_SEND_READY);
   end

   // Next-state and payload-capture logic for the single outstanding transaction.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      dv_d    = dv_q;
      idx_d   = idx_q;
      resp_d  = resp_q;
      case (state_q)
         ST_IDLE: begin
            // Ready equals the grant, so any request is a completed handshake.
            if (any_s) begin
               state_d = ST_REQ;
               addr_d  = sel_addr_s;
               data_d  = sel_data_s;
               dv_d    = sel_dv_s;
               idx_d   = gnt_idx_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (MASTER_SEND_READY) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_RESP: begin
            if (MASTER_RECEIVE_VALID) begin
               state_d = ST_RET;
               resp_d  = MASTER_RECEIVE_DATA;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_RET: begin
            if (ret_ack_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RET;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and payload registers; reset drops any in-flight transaction.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         idx_q   <= '0;
         resp_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         dv_q    <= dv_d;
         idx_q   <= idx_d;
         resp_q  <= resp_d;
      end
   end

   // Request ready is combinational from the grant but forced low during reset.
   assign SLAVE_RECEIVE_READY    = ((state_q == ST_IDLE) && !RST) ? gnt_s : '0;
   assign MASTER_SEND_ADDR_VALID = (state_q == ST_REQ);
   assign MASTER_SEND_ADDR       = addr_q;
   assign MASTER_SEND_DATA_VALID = dv_q;
   assign MASTER_SEND_DATA       = data_q;
   assign MASTER_RECEIVE_READY   = (state_q == ST_RESP);
   assign SLAVE_SEND_VALID       = ret_vec_s;
   assign SLAVE_SEND_DATA        = {CONNECT_NUM{resp_q}};

endmodule

// File: tb/tb_connect_mc.sv
// Self-checking bench for connect_mc: randomized request sets checked against
// a reference model that serves pending slaves highest-index first.
module tb_connect_mc;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int N  = 3;

   logic            CLK = 1'b0;
   logic            RST;
   logic [N-1:0]    sl_av, sl_dv, sl_rdy, sl_sv, sl_sr;
   logic [AW*N-1:0] sl_addr;
   logic [DW*N-1:0] sl_data, sl_sd;
   logic            m_av, m_dv, m_sr, m_rv, m_rr;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_data, m_rd;

   logic [AW-1:0]   a_tab [N];
   logic [DW-1:0]   d_tab [N];
   logic            dv_tab [N];

   int err_cnt = 0;
   int chk_cnt = 0;

   connect_mc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CONNECT_NUM(N)) dut (
      .CLK                      (CLK),
      .RST                      (RST),
      .SLAVE_RECEIVE_ADDR_VALID (sl_av),
      .SLAVE_RECEIVE_ADDR       (sl_addr),
      .SLAVE_RECEIVE_DATA_VALID (sl_dv),
      .SLAVE_RECEIVE_DATA       (sl_data),
      .SLAVE_RECEIVE_READY      (sl_rdy),
      .SLAVE_SEND_VALID         (sl_sv),
      .SLAVE_SEND_DATA          (sl_sd),
      .SLAVE_SEND_READY         (sl_sr),
      .MASTER_SEND_ADDR_VALID   (m_av),
      .MASTER_SEND_ADDR         (m_addr),
      .MASTER_SEND_DATA_VALID   (m_dv),
      .MASTER_SEND_DATA         (m_data),
      .MASTER_SEND_READY        (m_sr),
      .MASTER_RECEIVE_VALID     (m_rv),
      .MASTER_RECEIVE_DATA      (m_rd),
      .MASTER_RECEIVE_READY     (m_rr)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic load_slaves();
      for (int i = 0; i < N; i++) begin
         sl_addr[i*AW +: AW] = a_tab[i];
         sl_data[i*DW +: DW] = d_tab[i];
         sl_dv[i]            = dv_tab[i];
      end
   endtask

   task automatic check_quiet(input string tag);
      check_val({tag, "_rdy"}, 64'(sl_rdy), 64'd0);
      check_val({tag, "_sv"},  64'(sl_sv),  64'd0);
      check_val({tag, "_mav"}, 64'(m_av),   64'd0);
      check_val({tag, "_mrr"}, 64'(m_rr),   64'd0);
   endtask

   // Serve every slave in 'req' until none is pending. Model: the next winner
   // is the highest pending index; a withdrawn slave is simply removed.
   task automatic run_round(input logic [N-1:0] req, input bit withdraw);
      logic [N-1:0]  pend;
      logic [DW-1:0] resp;
      int            w;
      int            k;
      pend  = req;
      load_slaves();
      sl_av = req;
      while (pend != '0) begin
         w = -1;
         for (int i = N - 1; i >= 0; i--) begin
            if (pend[i] && w < 0) w = i;
         end
         #1;
         check_val("grant", 64'(sl_rdy), 64'(onehot(w)));
         step();
         sl_av[w] = 1'b0;
         pend[w]  = 1'b0;
         if (withdraw && pend != '0 && $urandom_range(0, 2) == 0) begin
            for (int i = 0; i < N; i++) begin
               if (pend[i]) begin
                  pend[i]  = 1'b0;
                  sl_av[i] = 1'b0;
                  break;
               end
            end
         end
         #1;
         check_val("m_av",      64'(m_av),   64'd1);
         check_val("m_addr",    64'(m_addr), 64'(a_tab[w]));
         check_val("m_data",    64'(m_data), 64'(d_tab[w]));
         check_val("m_dv",      64'(m_dv),   64'(dv_tab[w]));
         check_val("busy_rdy",  64'(sl_rdy), 64'd0);
         k = $urandom_range(0, 5);
         repeat (k) begin
            step();
            check_val("hold_m_av",   64'(m_av),   64'd1);
            check_val("hold_m_addr", 64'(m_addr), 64'(a_tab[w]));
            check_val("hold_m_data", 64'(m_data), 64'(d_tab[w]));
         end
         m_sr = 1'b1;
         step();
         m_sr = 1'b0;
         check_val("req_done_av", 64'(m_av), 64'd0);
         check_val("resp_rr",     64'(m_rr), 64'd1);
         k = $urandom_range(0, 2);
         repeat (k) begin
            step();
            check_val("wait_rr", 64'(m_rr), 64'd1);
         end
         resp = DW'($urandom);
         m_rv = 1'b1;
         m_rd = resp;
         step();
         m_rv = 1'b0;
         m_rd = DW'($urandom);
         #1;
         check_val("ret_rr",    64'(m_rr),               64'd0);
         check_val("ret_sv",    64'(sl_sv),              64'(onehot(w)));
         check_val("ret_data",  64'(sl_sd[w*DW +: DW]),  64'(resp));
         check_val("ret_bcast", 64'(sl_sd[((w+1)%N)*DW +: DW]), 64'(resp));
         check_val("ret_rdy",   64'(sl_rdy),             64'd0);
         k = $urandom_range(0, 3);
         repeat (k) begin
            sl_sr = N'($urandom) & ~onehot(w);
            step();
            check_val("hold_sv",   64'(sl_sv),             64'(onehot(w)));
            check_val("hold_data", 64'(sl_sd[w*DW +: DW]), 64'(resp));
         end
         sl_sr = onehot(w);
         step();
         sl_sr = '0;
         check_val("done_sv", 64'(sl_sv), 64'd0);
      end
      #1;
      check_quiet("idle");
   endtask

   initial begin
      RST   = 1'b1;
      sl_av = '0; sl_dv = '0; sl_sr = '0; sl_addr = '0; sl_data = '0;
      m_sr  = 1'b0; m_rv = 1'b0; m_rd = '0;

      // Reset with randomized inputs: every valid and ready output stays low.
      repeat (2) begin
         sl_av   = N'($urandom);
         sl_dv   = N'($urandom);
         sl_sr   = N'($urandom);
         sl_addr = {$urandom, $urandom, $urandom};
         sl_data = {$urandom, $urandom, $urandom};
         m_sr    = 1'($urandom);
         m_rv    = 1'($urandom);
         m_rd    = DW'($urandom);
         #1;
         check_quiet("rst");
         step();
      end
      sl_av = '0; sl_sr = '0; m_sr = 1'b0; m_rv = 1'b0;
      RST   = 1'b0;
      step();
      check_quiet("post_rst");
      check_val("post_rst_maddr", 64'(m_addr), 64'd0);

      // Single slave with known values.
      for (int i = 0; i < N; i++) begin
         a_tab[i] = AW'($urandom); d_tab[i] = DW'($urandom); dv_tab[i] = 1'b0;
      end
      a_tab[1] = 32'h1234_5678; d_tab[1] = 32'hDEAD_BEEF; dv_tab[1] = 1'b1;
      run_round(3'b010, 1'b0);

      // Contention with random payloads and data-valid flags.
      for (int it = 0; it < 100; it++) begin
         for (int i = 0; i < N; i++) begin
            a_tab[i]  = AW'($urandom);
            d_tab[i]  = DW'($urandom);
            dv_tab[i] = 1'($urandom);
         end
         if (it < 50) run_round(3'b111, 1'b0);
         else         run_round(N'($urandom_range(1, 7)), 1'b1);
      end

      // Reset while waiting for the master's response.
      a_tab[1] = AW'($urandom); d_tab[1] = DW'($urandom); dv_tab[1] = 1'b1;
      load_slaves();
      sl_av = 3'b010;
      step();
      sl_av = 3'b000;
      m_sr  = 1'b1;
      step();
      m_sr  = 1'b0;
      check_val("mid_rr", 64'(m_rr), 64'd1);
      sl_av = 3'b111;
      RST   = 1'b1;
      #1;
      check_quiet("mid_rst");
      step();
      sl_av = '0;
      RST   = 1'b0;
      step();
      check_quiet("mid_post");
      a_tab[0] = AW'($urandom); d_tab[0] = DW'($urandom); dv_tab[0] = 1'b1;
      run_round(3'b001, 1'b0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
